// File: rtl/fpnew_pkg.sv
// -----------------------------------------------------------------------------
// fpnew_pkg
//   Shared floating-point definitions for this slice of the FPU datapath:
//   format encoding, status flag layout, width helpers and the result-packer
//   FSM state type.
//   No ports (package).
// -----------------------------------------------------------------------------
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4,
        FP8ALT  = 3'd5
    } fp_format_e;

    // IEEE exception flags, NX in bit 0.
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    // Result packer: IDLE = no partial word held, FILL = at least one slot used.
    typedef enum logic {
        IDLE,
        FILL
    } packer_state_e;

    // Width in bits of one element of the given format (0 for unused codes).
    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:            return 32;
            FP64:            return 64;
            FP16, FP16ALT:   return 16;
            FP8, FP8ALT:     return 8;
            default:         return 0;
        endcase
    endfunction

    // log2 of the element width in bytes; lets slot arithmetic use shifts.
    function automatic logic [1:0] fp_byte_shift(fp_format_e fmt);
        case (fmt)
            FP32:            return 2'd2;
            FP64:            return 2'd3;
            FP16, FP16ALT:   return 2'd1;
            default:         return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fpnew_sdotp_result_packer.sv
// -----------------------------------------------------------------------------
// fpnew_sdotp_result_packer
//   Packs a stream of single dst-format results into LaneWidth-wide words.
//   Unused upper slots are NaN-boxed (all ones); status flags and extension
//   bits are OR-merged per word; tag/aux follow the last element of the word.
//
//   Ports
//     clk_i, rst_i          clock, synchronous active-high reset
//     result_i, dst_fmt_i   element (bits [W-1:0]) and its format
//     status_i              element exception flags
//     extension_bit_i       element extension bit
//     tag_i, aux_i          element side-band, carried through
//     last_i                element closes the current word
//     in_valid_i/in_ready_o element handshake
//     flush_i               synchronous discard of all state
//     result_o, count_o     packed word and number of filled slots
//     status_o              OR of element flags in the word
//     extension_bit_o       OR of element extension bits in the word
//     tag_o, aux_o          side-band of the last element in the word
//     out_valid_o/out_ready_i word handshake
//     busy_o                partial word held or output word pending
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   A producer holds valid and its payload stable until that edge; ready may
//   depend combinationally on valid and the payload, never the other way round.
// -----------------------------------------------------------------------------
module fpnew_sdotp_result_packer
    import fpnew_pkg::*;
#(
    parameter int unsigned LaneWidth = 64,
    parameter int unsigned ResWidth  = 32,
    parameter type         TagType   = logic,
    parameter type         AuxType   = logic,
    localparam int unsigned CountWidth = $clog2(LaneWidth/8) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ResWidth-1:0]   result_i,
    input  fp_format_e            dst_fmt_i,
    input  status_t               status_i,
    input  logic                  extension_bit_i,
    input  TagType                tag_i,
    input  AuxType                aux_i,
    input  logic                  last_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  flush_i,
    output logic [LaneWidth-1:0]  result_o,
    output logic [CountWidth-1:0] count_o,
    output status_t               status_o,
    output logic                  extension_bit_o,
    output TagType                tag_o,
    output AuxType                aux_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o
);

    localparam int unsigned NumBytes     = LaneWidth / 8;
    localparam int unsigned ResBytes     = ResWidth / 8;
    localparam int unsigned IdxW         = $clog2(NumBytes);
    localparam int unsigned MaxElemWidth = (ResWidth < LaneWidth) ? ResWidth : LaneWidth;

    // ---------------- state ----------------
    packer_state_e          state_q, state_d;
    logic [LaneWidth-1:0]   acc_q;
    logic [CountWidth-1:0]  slot_q;
    fp_format_e             cur_fmt_q;
    status_t                status_acc_q;
    logic                   ext_acc_q;
    TagType                 tag_q;
    AuxType                 aux_q;

    logic                   out_valid_q;
    logic [LaneWidth-1:0]   result_q;
    logic [CountWidth-1:0]  count_q;
    status_t                status_q;
    logic                   ext_q;
    TagType                 tag_out_q;
    AuxType                 aux_out_q;

    // ---------------- control ----------------
    logic                   out_free;
    logic                   fmt_mismatch;
    fp_format_e             pack_fmt;
    logic [1:0]             elem_shift;
    logic [CountWidth-1:0]  num_slots;
    logic                   completes;
    logic                   in_ready;
    logic                   accept;
    logic                   close_partial;
    logic [CountWidth-1:0]  fill_count;
    logic [IdxW-1:0]        sub_mask;

    always_comb begin
        out_free     = !out_valid_q || out_ready_i;
        fmt_mismatch = (state_q == FILL) && in_valid_i && (dst_fmt_i != cur_fmt_q);
        // While a word is being filled the slot geometry is fixed by its format;
        // an accepted element in FILL always matches it.
        pack_fmt     = (state_q == FILL) ? cur_fmt_q : dst_fmt_i;
        elem_shift   = fp_byte_shift(pack_fmt);
        num_slots    = CountWidth'(NumBytes) >> elem_shift;
        completes    = last_i || (slot_q == num_slots - CountWidth'(1));
        in_ready     = !rst_i && !flush_i && !fmt_mismatch && (!completes || out_free);
        accept       = in_valid_i && in_ready;
        // A format change seals the partial word as-is; the new element waits a cycle.
        close_partial = fmt_mismatch && out_free && !rst_i && !flush_i;
        // Slots at or above this index are boxed in the outgoing word.
        fill_count   = fmt_mismatch ? slot_q : slot_q + CountWidth'(1);
        sub_mask     = IdxW'((32'd1 << elem_shift) - 32'd1);
    end

    always_comb begin
        state_d = state_q;
        if (close_partial) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = completes ? IDLE : FILL;
        end
        if (rst_i || flush_i) begin
            state_d = IDLE;
        end
    end

    // ---------------- slot insert and NaN-boxing, per byte ----------------
    logic [7:0]           res_bytes [NumBytes];
    logic [LaneWidth-1:0] ins_word;
    logic [LaneWidth-1:0] packed_word;

    for (genvar k = 0; k < NumBytes; k++) begin : g_res
        if (k < ResBytes) begin : g_in
            assign res_bytes[k] = result_i[k*8 +: 8];
        end else begin : g_pad
            assign res_bytes[k] = 8'h00;
        end
    end

    for (genvar b = 0; b < NumBytes; b++) begin : g_byte
        logic [CountWidth-1:0] b_slot;  // slot this byte belongs to
        logic [IdxW-1:0]       b_sub;   // byte position inside that slot
        assign b_slot = CountWidth'(b) >> elem_shift;
        assign b_sub  = IdxW'(b) & sub_mask;
        assign ins_word[b*8 +: 8]    = (b_slot == slot_q) ? res_bytes[b_sub] : acc_q[b*8 +: 8];
        assign packed_word[b*8 +: 8] = (b_slot >= fill_count) ? 8'hFF : ins_word[b*8 +: 8];
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            slot_q       <= '0;
            cur_fmt_q    <= FP32;
            status_acc_q <= '0;
            ext_acc_q    <= 1'b0;
            tag_q        <= '0;
            aux_q        <= '0;
            out_valid_q  <= 1'b0;
            result_q     <= '1;
            count_q      <= '0;
            status_q     <= '0;
            ext_q        <= 1'b0;
            tag_out_q    <= '0;
            aux_out_q    <= '0;
        end else begin
            state_q <= state_d;
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (close_partial) begin
                out_valid_q  <= 1'b1;
                result_q     <= packed_word;
                count_q      <= slot_q;
                status_q     <= status_acc_q;
                ext_q        <= ext_acc_q;
                tag_out_q    <= tag_q;
                aux_out_q    <= aux_q;
                slot_q       <= '0;
                status_acc_q <= '0;
                ext_acc_q    <= 1'b0;
            end else if (accept) begin
                if (completes) begin
                    out_valid_q  <= 1'b1;
                    result_q     <= packed_word;
                    count_q      <= slot_q + CountWidth'(1);
                    status_q     <= status_t'(status_acc_q | status_i);
                    ext_q        <= ext_acc_q | extension_bit_i;
                    tag_out_q    <= tag_i;
                    aux_out_q    <= aux_i;
                    slot_q       <= '0;
                    status_acc_q <= '0;
                    ext_acc_q    <= 1'b0;
                end else begin
                    acc_q        <= ins_word;
                    slot_q       <= slot_q + CountWidth'(1);
                    status_acc_q <= status_t'(status_acc_q | status_i);
                    ext_acc_q    <= ext_acc_q | extension_bit_i;
                    tag_q        <= tag_i;
                    aux_q        <= aux_i;
                    cur_fmt_q    <= dst_fmt_i;
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign in_ready_o      = in_ready;
    assign result_o        = result_q;
    assign count_o         = count_q;
    assign status_o        = status_q;
    assign extension_bit_o = ext_q;
    assign tag_o           = tag_out_q;
    assign aux_o           = aux_out_q;
    assign out_valid_o     = out_valid_q;
    assign busy_o          = (state_q == FILL) || out_valid_q;

    // ---------------- design-error checks ----------------
    fmt_legal_a: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        in_valid_i |-> (fp_width(dst_fmt_i) != 0 && fp_width(dst_fmt_i) <= MaxElemWidth));

    slot_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == FILL) |->
            (slot_q != '0 && slot_q < (CountWidth'(NumBytes) >> fp_byte_shift(cur_fmt_q))));

endmodule

// File: tb/tb_fpnew_sdotp_result_packer.sv
module tb_fpnew_sdotp_result_packer;
  import fpnew_pkg::*;

  localparam int LW = 64;
  localparam int RW = 32;
  localparam int CW = $clog2(LW/8) + 1;

  typedef logic [3:0] tag_t;
  typedef logic [2:0] aux_t;

  typedef struct {
    fp_format_e  fmt;
    logic [31:0] data;
    logic [4:0]  st;
    logic        ext;
    tag_t        tag;
    aux_t        aux;
    logic        last;
  } elem_t;

  typedef struct {
    logic [63:0] data;
    int          count;
    logic [4:0]  st;
    logic        ext;
    tag_t        tag;
    aux_t        aux;
    int          cyc;
  } word_t;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [RW-1:0] result_i;
  fp_format_e    dst_fmt_i;
  status_t       status_i;
  logic          extension_bit_i;
  tag_t          tag_i;
  aux_t          aux_i;
  logic          last_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          flush_i;
  logic [LW-1:0] result_o;
  logic [CW-1:0] count_o;
  status_t       status_o;
  logic          extension_bit_o;
  tag_t          tag_o;
  aux_t          aux_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          busy_o;

  fpnew_sdotp_result_packer #(
    .LaneWidth(LW),
    .ResWidth (RW),
    .TagType  (tag_t),
    .AuxType  (aux_t)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .result_i       (result_i),
    .dst_fmt_i      (dst_fmt_i),
    .status_i       (status_i),
    .extension_bit_i(extension_bit_i),
    .tag_i          (tag_i),
    .aux_i          (aux_i),
    .last_i         (last_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .flush_i        (flush_i),
    .result_o       (result_o),
    .count_o        (count_o),
    .status_o       (status_o),
    .extension_bit_o(extension_bit_o),
    .tag_o          (tag_o),
    .aux_o          (aux_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .busy_o         (busy_o)
  );

  // ---------------- scoreboard ----------------
  int tests  = 0;
  int failed = 0;

  elem_t part_q[$];   // elements of the word being built
  word_t exp_q[$];    // words the DUT still owes
  word_t got_q[$];    // every word consumed, for directed checks
  int    last_acc_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int width_of(fp_format_e f);
    case (f)
      FP8, FP8ALT:   return 8;
      FP16, FP16ALT: return 16;
      FP32:          return 32;
      default:       return 64;
    endcase
  endfunction

  // Seal the collected elements into one expected word.
  function automatic void model_close();
    word_t w;
    int    wd;
    int    n;
    logic [63:0] ones;
    wd = width_of(part_q[0].fmt);
    n  = LW / wd;
    ones = (wd == 64) ? '1 : ((64'd1 << wd) - 64'd1);
    w.data = '0;
    w.st   = '0;
    w.ext  = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [63:0] s;
      s = (i < part_q.size()) ? (64'(part_q[i].data) & ones) : ones;
      w.data = w.data | (s << (i * wd));
    end
    foreach (part_q[i]) begin
      w.st  = w.st | part_q[i].st;
      w.ext = w.ext | part_q[i].ext;
    end
    w.count = part_q.size();
    w.tag   = part_q[part_q.size()-1].tag;
    w.aux   = part_q[part_q.size()-1].aux;
    w.cyc   = 0;
    exp_q.push_back(w);
    part_q.delete();
  endfunction

  function automatic void model_push(input elem_t e);
    if (part_q.size() != 0 && e.fmt != part_q[0].fmt) model_close();
    part_q.push_back(e);
    if (part_q.size() == LW / width_of(e.fmt) || e.last) model_close();
  endfunction

  // ---------------- compare process ----------------
  logic  hold_valid = 1'b0;
  word_t held;

  always @(negedge clk_i) begin
    if (rst_i || flush_i) begin
      part_q.delete();
      exp_q.delete();
      hold_valid = 1'b0;
    end else begin
      word_t ob;
      chk("busy", 64'(busy_o), 64'((part_q.size() != 0) || out_valid_o));
      if (in_valid_i && in_ready_o) begin
        elem_t e;
        e.fmt = dst_fmt_i; e.data = result_i; e.st = status_i;
        e.ext = extension_bit_i; e.tag = tag_i; e.aux = aux_i; e.last = last_i;
        model_push(e);
        last_acc_cyc = cyc;
      end
      ob.data = result_o; ob.count = int'(count_o); ob.st = status_o;
      ob.ext = extension_bit_o; ob.tag = tag_o; ob.aux = aux_o; ob.cyc = cyc;
      if (out_valid_o) begin
        if (hold_valid) begin
          chk("hold_result", ob.data, held.data);
          chk("hold_count", 64'(ob.count), 64'(held.count));
          chk("hold_side", {ob.st, ob.ext, ob.tag, ob.aux}, {held.st, held.ext, held.tag, held.aux});
        end
        if (out_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", ob.data, 64'hDEAD_DEAD_DEAD_DEAD);
          end else begin
            word_t x;
            x = exp_q.pop_front();
            chk("word_result", ob.data, x.data);
            chk("word_count", 64'(ob.count), 64'(x.count));
            chk("word_status", 64'(ob.st), 64'(x.st));
            chk("word_ext", 64'(ob.ext), 64'(x.ext));
            chk("word_tag", 64'(ob.tag), 64'(x.tag));
            chk("word_aux", 64'(ob.aux), 64'(x.aux));
          end
          got_q.push_back(ob);
          hold_valid = 1'b0;
        end else begin
          hold_valid = 1'b1;
          held = ob;
        end
      end else if (hold_valid) begin
        chk("valid_dropped", 64'(out_valid_o), 64'd1);
        hold_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic rand_rdy = 1'b0;
  int   rel_at   = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_rdy) out_ready_i = 1'($urandom_range(0, 1));
    else if (rel_at > 0 && cyc >= rel_at) begin
      out_ready_i = 1'b1;
      rel_at = 0;
    end
  endtask

  task automatic send(input fp_format_e f, input logic [31:0] d, input logic [4:0] st,
                      input logic ext, input tag_t tg, input aux_t ax, input logic lst,
                      output int stalls);
    logic done;
    logic rdy;
    dst_fmt_i = f; result_i = d; status_i = status_t'(st);
    extension_bit_i = ext; tag_i = tg; aux_i = ax; last_i = lst;
    in_valid_i = 1'b1;
    stalls = 0;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk_i);
      rdy = in_ready_o;
      tick();
      if (rdy) done = 1'b1;
      else stalls++;
    end
    in_valid_i = 1'b0;
    last_i = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_s(input fp_format_e f, input logic [31:0] d, input logic lst);
    int s;
    send(f, d, 5'b0, 1'b0, 4'h0, 3'h0, lst, s);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk_i);
      if (!busy_o) done = 1'b1;
      else tick();
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
    else tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    int s;
    fp_format_e fmts[5];
    fp_format_e f;
    fmts = '{FP8, FP16, FP32, FP16ALT, FP8ALT};

    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    in_valid_i = 1'b1; dst_fmt_i = FP32; result_i = '0; status_i = '0;
    extension_bit_i = 1'b0; tag_i = '0; aux_i = '0; last_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_result", result_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_side", {status_o, extension_bit_o, tag_o, aux_o}, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; in_valid_i = 1'b0; last_i = 1'b0;
    @(negedge clk_i);
    chk("idle_ready", 64'(in_ready_o), 64'd1);
    tick();

    // Four FP16 elements, one full word, latency one cycle.
    n0 = got_q.size();
    send_s(FP16, 32'h3C00, 1'b0);
    send_s(FP16, 32'h4000, 1'b0);
    send_s(FP16, 32'h4200, 1'b0);
    send_s(FP16, 32'h4400, 1'b0);
    drain();
    chk("t1_nwords", 64'(got_q.size() - n0), 64'd1);
    if (got_q.size() > n0) begin
      chk("t1_word", got_q[n0].data, 64'h4400_4200_4000_3C00);
      chk("t1_count", 64'(got_q[n0].count), 64'd4);
      chk("t1_latency", 64'(got_q[n0].cyc - last_acc_cyc), 64'd1);
    end

    // FP8 pair closed by last_i.
    n0 = got_q.size();
    send_s(FP8, 32'h38, 1'b0);
    send_s(FP8, 32'h40, 1'b1);
    drain();
    chk("t2_nwords", 64'(got_q.size() - n0), 64'd1);
    if (got_q.size() > n0) begin
      chk("t2_word", got_q[n0].data, 64'hFFFF_FFFF_FFFF_4038);
      chk("t2_count", 64'(got_q[n0].count), 64'd2);
    end

    // Format change seals the FP16 word after a one-cycle stall.
    n0 = got_q.size();
    send_s(FP16, 32'h3C00, 1'b0);
    send(FP32, 32'h3F80_0000, 5'b0, 1'b0, 4'h0, 3'h0, 1'b0, s);
    chk("t3_stall", 64'(s), 64'd1);
    send_s(FP32, 32'h4000_0000, 1'b0);
    drain();
    chk("t3_nwords", 64'(got_q.size() - n0), 64'd2);
    if (got_q.size() > n0 + 1) begin
      chk("t3_word0", got_q[n0].data, 64'hFFFF_FFFF_FFFF_3C00);
      chk("t3_count0", 64'(got_q[n0].count), 64'd1);
      chk("t3_word1", got_q[n0+1].data, 64'h4000_0000_3F80_0000);
    end

    // Backpressure: full FP32 word pending, one more accepted, next stalled.
    n0 = got_q.size();
    out_ready_i = 1'b0;
    send_s(FP32, 32'h3F80_0000, 1'b0);
    send_s(FP32, 32'hC000_0000, 1'b0);
    send_s(FP32, 32'h4040_0000, 1'b0);
    rel_at = cyc + 5;
    send(FP32, 32'h4080_0000, 5'b0, 1'b0, 4'h0, 3'h0, 1'b0, s);
    chk("t4_stalled", 64'(s >= 3), 64'd1);
    drain();
    chk("t4_nwords", 64'(got_q.size() - n0), 64'd2);
    if (got_q.size() > n0 + 1) begin
      chk("t4_word0", got_q[n0].data, 64'hC000_0000_3F80_0000);
      chk("t4_word1", got_q[n0+1].data, 64'h4080_0000_4040_0000);
    end

    // Status/ext merge, tag/aux from the completing element.
    n0 = got_q.size();
    send(FP32, 32'h3F80_0000, 5'b00001, 1'b0, 4'h5, 3'h3, 1'b0, s);
    send(FP32, 32'h7F80_0000, 5'b00100, 1'b1, 4'h9, 3'h6, 1'b0, s);
    drain();
    if (got_q.size() > n0) begin
      chk("t5_status", 64'(got_q[n0].st), 64'b00101);
      chk("t5_ext", 64'(got_q[n0].ext), 64'd1);
      chk("t5_tag", 64'(got_q[n0].tag), 64'h9);
      chk("t5_aux", 64'(got_q[n0].aux), 64'h6);
    end else chk("t5_nwords", 64'(got_q.size() - n0), 64'd1);

    // Flush mid-word, then a clean FP8 word.
    n0 = got_q.size();
    send_s(FP8, 32'h11, 1'b0);
    send_s(FP8, 32'h22, 1'b0);
    send_s(FP8, 32'h33, 1'b0);
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("t6_flush_ready", 64'(in_ready_o), 64'd0);
    tick();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_out_valid", 64'(out_valid_o), 64'd0);
    chk("t6_nwords", 64'(got_q.size() - n0), 64'd0);
    tick();
    for (int i = 1; i <= 8; i++) send_s(FP8, 32'(i), 1'b0);
    drain();
    chk("t6_nwords2", 64'(got_q.size() - n0), 64'd1);
    if (got_q.size() > n0) begin
      chk("t6_word", got_q[n0].data, 64'h0807_0605_0403_0201);
      chk("t6_count", 64'(got_q[n0].count), 64'd8);
    end

    // Random traffic with random backpressure.
    rand_rdy = 1'b1;
    f = FP16;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) f = fmts[$urandom_range(0, 4)];
      send(f, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 7) == 0), s);
    end
    send(f, $urandom, 5'b0, 1'b0, 4'h1, 3'h1, 1'b1, s);
    rand_rdy = 1'b0;
    out_ready_i = 1'b1;
    drain();
    chk("rand_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("rand_part_empty", 64'(part_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

endmodule
